// File: rtl/display_arb_pkg.sv
// Shared types and constants for the display arbiter slice.
package display_arb_pkg;

    localparam int unsigned OWNER_W       = 3;
    localparam int unsigned MAX_REQ       = 8;
    localparam logic [31:0] BLANK_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        EMPTY,
        SHOW
    } arb_state_t;

    // Index of the lowest set bit of an up-to-8-wide mask (0 when the mask is empty).
    function automatic logic [OWNER_W-1:0] lowest_index(input logic [MAX_REQ-1:0] mask);
        logic [OWNER_W-1:0] idx;
        idx = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (mask[i]) idx = OWNER_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/display_arbiter_rr_next_pick.sv
// Cyclic search for the next occupied slot strictly after `current`,
// wrapping NREQ-1 -> 0; `current` itself is the last candidate considered.
module rr_next_pick
    import display_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0]    occupied,
    input  logic [OWNER_W-1:0] current,
    output logic [OWNER_W-1:0] next,
    output logic               found
);

    int unsigned off;
    int unsigned best_off;

    // Pick the occupied index with the smallest forward distance from current.
    always_comb begin
        next     = current;
        found    = 1'b0;
        off      = 0;
        best_off = NREQ + 1;
        for (int unsigned j = 0; j < NREQ; j++) begin
            off = (j + NREQ - 32'(current)) % NREQ;
            if (off == 0) off = NREQ;
            if (occupied[j] && (off < best_off)) begin
                best_off = off;
                next     = OWNER_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Shares one 32-bit display value among NREQ requester slots with a
// tick-based round-robin dwell and an urgent, preempting slot 0.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned HOLD_TICKS  = 4,
    parameter logic [31:0] BLANK_VALUE = BLANK_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_data,
    input  logic [NREQ-1:0]      req_release,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          data_vector,
    output logic [OWNER_W-1:0]   owner,
    output logic                 owner_valid
);

    localparam int unsigned      CNT_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TICKS - 1);

    logic [NREQ-1:0]    post;
    logic [NREQ-1:0]    occ_q;
    logic [NREQ-1:0]    occ_next;
    logic [31:0]        slot_q [NREQ];

    arb_state_t         state_q, state_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               owner_post;
    logic               owner_rel;
    logic [31:0]        owner_slot;
    logic [31:0]        data_d;
    logic [MAX_REQ-1:0] post_ext;

    logic [OWNER_W-1:0] pick_idx;
    logic               pick_found;

    assign req_ready = {NREQ{reset_n}};
    assign post      = req_valid & req_ready;
    // A post in the same cycle as a release keeps the slot occupied.
    assign occ_next  = (occ_q & ~req_release) | post;

    // Slot payload registers and occupied flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ_q <= '0;
            for (int unsigned i = 0; i < NREQ; i++) slot_q[i] <= '0;
        end else begin
            occ_q <= occ_next;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (post[i]) slot_q[i] <= req_data[32*i +: 32];
            end
        end
    end

    // Per-owner views of this cycle's post, release and stored payload.
    always_comb begin
        owner_post = 1'b0;
        owner_rel  = 1'b0;
        owner_slot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == OWNER_W'(i)) begin
                owner_post = post[i];
                owner_rel  = req_release[i];
                owner_slot = slot_q[i];
            end
        end
    end

    // Searches against next-cycle occupancy so rotation and owner release see same-cycle traffic.
    rr_next_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .occupied (occ_next),
        .current  (owner_q),
        .next     (pick_idx),
        .found    (pick_found)
    );

    // FSM state register: state, owner and dwell counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: preempt beats owner release, which beats dwell rotation.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        post_ext = '0;
        post_ext[NREQ-1:0] = post;
        unique case (state_q)
            EMPTY: begin
                cnt_d = '0;
                if (|post) begin
                    state_d = SHOW;
                    owner_d = lowest_index(post_ext);
                end
            end
            SHOW: begin
                if (post[0] && (owner_q != '0)) begin
                    owner_d = '0;
                    cnt_d   = '0;
                end else if (owner_rel && !owner_post) begin
                    cnt_d = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = EMPTY;
                        owner_d = '0;
                    end
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        owner_d = pick_found ? pick_idx : owner_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: owner flags direct from state, display value staged for the output register.
    always_comb begin
        owner_valid = (state_q == SHOW);
        owner       = owner_q;
        data_d      = (state_q == SHOW) ? owner_slot : BLANK_VALUE;
    end

    // Registered display value feeding the MAX7219 driver.
    always_ff @(posedge clk) begin
        if (!reset_n) data_vector <= BLANK_VALUE;
        else          data_vector <= data_d;
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed vector table, a dwell
// timing sequence, and randomized traffic against a behavioural model.
module tb_display_arbiter;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned HOLD  = 4;
    localparam logic [31:0] BLANK = 32'h0000_0000;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 tick = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*32-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_release = '0;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          data_vector;
    logic [2:0]           owner;
    logic                 owner_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_arbiter #(
        .NREQ        (NREQ),
        .HOLD_TICKS  (HOLD),
        .BLANK_VALUE (BLANK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_release (req_release),
        .req_ready   (req_ready),
        .data_vector (data_vector),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [2:0]  valid;
        logic [95:0] data;
        logic [2:0]  rel;
        logic        tk;
        logic        rn;
        logic [2:0]  eo;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  er;
    } vec_t;

    vec_t vecs[$];

    function automatic void push(input logic [2:0] v, input logic [31:0] d2, input logic [31:0] d1,
                                 input logic [31:0] d0, input logic [2:0] rel, input logic tk,
                                 input logic rn, input logic [2:0] eo, input logic ev,
                                 input logic [31:0] ed);
        vec_t r;
        r.valid = v;
        r.data  = {d2, d1, d0};
        r.rel   = rel;
        r.tk    = tk;
        r.rn    = rn;
        r.eo    = eo;
        r.ev    = ev;
        r.ed    = ed;
        r.er    = rn ? 3'b111 : 3'b000;
        vecs.push_back(r);
    endfunction

    function automatic void idle(input logic [2:0] eo, input logic ev, input logic [31:0] ed);
        push(3'b000, 0, 0, 0, 3'b000, 1'b0, 1'b1, eo, ev, ed);
    endfunction

    function automatic void tk(input logic [2:0] eo, input logic ev, input logic [31:0] ed);
        push(3'b000, 0, 0, 0, 3'b000, 1'b1, 1'b1, eo, ev, ed);
    endfunction

    function automatic void build_table();
        // reset held with posts pending
        push(3'b111, 32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 3'b000, 1'b1, 1'b0, 0, 0, BLANK);
        push(3'b111, 32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 3'b000, 1'b0, 1'b0, 0, 0, BLANK);
        idle(0, 0, BLANK);
        idle(0, 0, BLANK);
        // single post on slot 2
        push(3'b100, 32'h1234ABCD, 0, 0, 3'b000, 1'b0, 1'b1, 2, 1, BLANK);
        idle(2, 1, 32'h1234ABCD);
        for (int k = 0; k < 10; k++) tk(2, 1, 32'h1234ABCD);
        push(3'b000, 0, 0, 0, 3'b100, 1'b0, 1'b1, 0, 0, 32'h1234ABCD);
        idle(0, 0, BLANK);
        // rotation between slots 1 and 2, with an owner re-post mid-dwell
        push(3'b110, 32'h22222222, 32'h11111111, 0, 3'b000, 1'b0, 1'b1, 1, 1, BLANK);
        idle(1, 1, 32'h11111111);
        tk(1, 1, 32'h11111111);
        idle(1, 1, 32'h11111111);
        tk(1, 1, 32'h11111111);
        push(3'b010, 0, 32'h1111AAAA, 0, 3'b000, 1'b0, 1'b1, 1, 1, 32'h11111111);
        tk(1, 1, 32'h1111AAAA);
        tk(2, 1, 32'h1111AAAA);
        idle(2, 1, 32'h22222222);
        for (int k = 0; k < 3; k++) tk(2, 1, 32'h22222222);
        tk(1, 1, 32'h22222222);
        idle(1, 1, 32'h1111AAAA);
        for (int k = 0; k < 3; k++) tk(1, 1, 32'h1111AAAA);
        tk(2, 1, 32'h1111AAAA);
        idle(2, 1, 32'h22222222);
        for (int k = 0; k < 3; k++) tk(2, 1, 32'h22222222);
        // preempt by slot 0 on the tick that would have expired the dwell
        push(3'b001, 0, 0, 32'hDEAD0000, 3'b000, 1'b1, 1'b1, 0, 1, 32'h22222222);
        idle(0, 1, 32'hDEAD0000);
        for (int k = 0; k < 3; k++) tk(0, 1, 32'hDEAD0000);
        tk(1, 1, 32'hDEAD0000);
        idle(1, 1, 32'h1111AAAA);
        // owner release
        push(3'b000, 0, 0, 0, 3'b010, 1'b0, 1'b1, 2, 1, 32'h1111AAAA);
        idle(2, 1, 32'h22222222);
        push(3'b000, 0, 0, 0, 3'b001, 1'b0, 1'b1, 2, 1, 32'h22222222);
        push(3'b000, 0, 0, 0, 3'b100, 1'b0, 1'b1, 0, 0, 32'h22222222);
        idle(0, 0, BLANK);
        // same-cycle post and release, from EMPTY and while shown
        push(3'b010, 0, 32'h5A5A5A5A, 0, 3'b010, 1'b0, 1'b1, 1, 1, BLANK);
        idle(1, 1, 32'h5A5A5A5A);
        push(3'b010, 0, 32'h6B6B6B6B, 0, 3'b010, 1'b0, 1'b1, 1, 1, 32'h5A5A5A5A);
        idle(1, 1, 32'h6B6B6B6B);
        // reset mid-dwell drops a pending post
        tk(1, 1, 32'h6B6B6B6B);
        push(3'b001, 0, 0, 32'hFFFF0000, 3'b000, 1'b0, 1'b0, 0, 0, BLANK);
        idle(0, 0, BLANK);
        idle(0, 0, BLANK);
    endfunction

    // ---------------- behavioural reference model ----------------
    bit          m_occ [NREQ];
    logic [31:0] m_val [NREQ];
    bit          m_show;
    int          m_owner;
    int          m_ticks;
    logic [31:0] m_disp;

    function automatic int next_occ(input int from);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (from + k) % NREQ;
            if (m_occ[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic rn, input logic [2:0] v, input logic [95:0] d,
                                       input logic [2:0] rel, input logic t);
        logic [31:0] shown;
        int nx;
        bit any_post;
        if (!rn) begin
            for (int i = 0; i < NREQ; i++) begin
                m_occ[i] = 0;
                m_val[i] = '0;
            end
            m_show = 0; m_owner = 0; m_ticks = 0; m_disp = BLANK;
            return;
        end
        shown = m_show ? m_val[m_owner] : BLANK;
        any_post = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                m_val[i] = d[32*i +: 32];
                m_occ[i] = 1;
                any_post = 1;
            end else if (rel[i]) begin
                m_occ[i] = 0;
            end
        end
        if (!m_show) begin
            if (any_post) begin
                m_show = 1;
                m_ticks = 0;
                for (int i = NREQ - 1; i >= 0; i--) if (v[i]) m_owner = i;
            end
        end else if (v[0] && m_owner != 0) begin
            m_owner = 0;
            m_ticks = 0;
        end else if (!m_occ[m_owner]) begin
            m_ticks = 0;
            nx = next_occ(m_owner);
            if (nx < 0) begin
                m_show = 0;
                m_owner = 0;
            end else begin
                m_owner = nx;
            end
        end else if (t) begin
            m_ticks++;
            if (m_ticks == HOLD) begin
                m_ticks = 0;
                m_owner = next_occ(m_owner);
            end
        end
        m_disp = shown;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int ticks_seen;
        bit switched;

        build_table();
        foreach (vecs[i]) begin
            req_valid   = vecs[i].valid;
            req_data    = vecs[i].data;
            req_release = vecs[i].rel;
            tick        = vecs[i].tk;
            reset_n     = vecs[i].rn;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d owner", i), 32'(owner), 32'(vecs[i].eo));
            check($sformatf("vec%0d owner_valid", i), 32'(owner_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d data_vector", i), data_vector, vecs[i].ed);
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].er));
        end

        // dwell with sparse ticks: owner 0 must hold for exactly HOLD tick pulses
        req_valid = '0; req_release = '0; tick = 1'b0; reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        req_valid = 3'b101;
        req_data = {32'hCAFE0002, 32'h0, 32'hCAFE0000};
        @(posedge clk); #1;
        req_valid = '0;
        check("dwell start owner", 32'(owner), 32'd0);
        ticks_seen = 0;
        switched = 0;
        for (int c = 0; c < 120 && !switched; c++) begin
            tick = (c % 3 == 2);
            @(posedge clk);
            if (tick) ticks_seen++;
            #1;
            if (owner == 3'd2) switched = 1;
        end
        tick = 1'b0;
        check("dwell switched", 32'(switched), 32'd1);
        check("dwell tick count", 32'(ticks_seen), HOLD);
        @(posedge clk); #1;
        check("dwell data follows", data_vector, 32'hCAFE0002);

        // randomized traffic against the model
        reset_n = 1'b0;
        req_valid = '0; req_release = '0;
        @(posedge clk);
        model_step(reset_n, req_valid, req_data, req_release, tick);
        #1;
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i]   = (i == 0) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 7) == 0);
                req_release[i] = ($urandom_range(0, 9) == 0);
                req_data[32*i +: 32] = $urandom;
            end
            tick = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_step(reset_n, req_valid, req_data, req_release, tick);
            #1;
            check($sformatf("rnd%0d owner", c), 32'(owner), 32'(m_owner));
            check($sformatf("rnd%0d owner_valid", c), 32'(owner_valid), 32'(m_show));
            check($sformatf("rnd%0d data_vector", c), data_vector, m_disp);
            check($sformatf("rnd%0d req_ready", c), 32'(req_ready), reset_n ? 32'h7 : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
